// File: rtl/wb_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_controller_pkg
//  Description : Opcode constants, instruction classes and writeback FSM
//                states shared by the writeback and register-file controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_controller_pkg;

    localparam logic [3:0] c_op_load  = 4'b0000;
    localparam logic [3:0] c_op_stop  = 4'b0001;
    localparam logic [3:0] c_op_store = 4'b0010;
    localparam logic [3:0] c_op_asn_a = 4'b0100;
    localparam logic [3:0] c_op_asn_b = 4'b0110;
    localparam logic [3:0] c_op_asn_c = 4'b1000;
    localparam logic [3:0] c_op_bz    = 4'b0101;
    localparam logic [3:0] c_op_bnz   = 4'b1001;
    localparam logic [3:0] c_op_bpz   = 4'b1101;
    localparam logic [3:0] c_op_nop   = 4'b1010;

    // SHIFT and ORI are recognised by their low three opcode bits only
    localparam logic [2:0] c_low_shift = 3'b011;
    localparam logic [2:0] c_low_ori   = 3'b111;

    localparam logic [1:0] c_regw_ori = 2'd1;
    localparam logic [1:0] c_sel_alu  = 2'd0;
    localparam logic [1:0] c_sel_mdr  = 2'd1;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_ASN   = 4'd1,
        CLS_SHIFT = 4'd2,
        CLS_ORI   = 4'd3,
        CLS_LOAD  = 4'd4,
        CLS_STORE = 4'd5,
        CLS_BPZ   = 4'd6,
        CLS_BZ    = 4'd7,
        CLS_BNZ   = 4'd8,
        CLS_STOP  = 4'd9
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } wb_state_e;

    function automatic logic class_retires(input instr_class_e cls);
        return (cls != CLS_NOP) && (cls != CLS_STOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Maps a 4-bit opcode onto its instruction class.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import wb_controller_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_e instr_class
);

    always_comb begin
        instr_class = CLS_NOP;
        if (opcode[2:0] == c_low_shift) begin
            instr_class = CLS_SHIFT;
        end else if (opcode[2:0] == c_low_ori) begin
            instr_class = CLS_ORI;
        end else begin
            case (opcode)
                c_op_load:  instr_class = CLS_LOAD;
                c_op_stop:  instr_class = CLS_STOP;
                c_op_store: instr_class = CLS_STORE;
                c_op_asn_a,
                c_op_asn_b,
                c_op_asn_c: instr_class = CLS_ASN;
                c_op_bz:    instr_class = CLS_BZ;
                c_op_bnz:   instr_class = CLS_BNZ;
                c_op_bpz:   instr_class = CLS_BPZ;
                c_op_nop:   instr_class = CLS_NOP;
                default:    instr_class = CLS_NOP;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : wb_controller
//  Description : Writeback-stage controller: register-file write control,
//                STOP drain/halt sequencing and a saturating retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_controller
    import wb_controller_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  IR3Out,
    input  logic        Squash,
    output logic        RFWrite,
    output logic [1:0]  RegW,
    output logic [1:0]  RegInSel,
    output logic        PCWrite,
    output logic        Halted,
    output logic [15:0] RetiredCount
);

    instr_class_e w_dec_class;
    instr_class_e w_class;
    wb_state_e    r_state;
    wb_state_e    w_state_nxt;

    logic        r_rfwrite;
    logic        w_rfwrite_nxt;
    logic        r_retire;
    logic        w_retire_nxt;
    logic [1:0]  r_regw;
    logic [1:0]  w_regw_nxt;
    logic [1:0]  r_reginsel;
    logic [1:0]  w_reginsel_nxt;
    logic [15:0] r_retired_cnt;
    logic        w_unused_field_b;

    instr_decode u_instr_decode (
        .opcode      (IR3Out[3:0]),
        .instr_class (w_dec_class)
    );

    assign w_class          = Squash ? CLS_NOP : w_dec_class;
    assign w_unused_field_b = ^IR3Out[5:4];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_class == CLS_STOP) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_HALT;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Outside RUN the stage is fed a bubble so nothing can be written or retired
    always_comb begin
        w_rfwrite_nxt  = 1'b0;
        w_regw_nxt     = 2'd0;
        w_reginsel_nxt = c_sel_alu;
        w_retire_nxt   = 1'b0;
        if (r_state == ST_RUN) begin
            w_retire_nxt = class_retires(w_class);
            case (w_class)
                CLS_ASN, CLS_SHIFT: begin
                    w_rfwrite_nxt = 1'b1;
                    w_regw_nxt    = IR3Out[7:6];
                end
                CLS_ORI: begin
                    w_rfwrite_nxt = 1'b1;
                    w_regw_nxt    = c_regw_ori;
                end
                CLS_LOAD: begin
                    w_rfwrite_nxt  = 1'b1;
                    w_regw_nxt     = IR3Out[7:6];
                    w_reginsel_nxt = c_sel_mdr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_rfwrite     <= 1'b0;
            r_regw        <= 2'd0;
            r_reginsel    <= c_sel_alu;
            r_retire      <= 1'b0;
            r_retired_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rfwrite  <= w_rfwrite_nxt;
            r_regw     <= w_regw_nxt;
            r_reginsel <= w_reginsel_nxt;
            r_retire   <= w_retire_nxt;
            if ((r_state == ST_RUN) && r_retire && (r_retired_cnt != 16'hFFFF)) begin
                r_retired_cnt <= r_retired_cnt + 16'd1;
            end
        end
    end

    assign RFWrite      = r_rfwrite;
    assign RegW         = r_regw;
    assign RegInSel     = r_reginsel;
    assign PCWrite      = (r_state == ST_RUN);
    assign Halted       = (r_state == ST_HALT);
    assign RetiredCount = r_retired_cnt;

endmodule
`default_nettype wire

// File: doc/wb_controller.md
WB_CONTROLLER -- requirements
Module: wb_controller

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: the only reset; synchronous, active-low (0 = reset).
REQ-003 The block SHALL have port IR3Out, input, 8 bits: the instruction latched into writeback at the next edge; [3:0] is the opcode, [7:6] is field A, [5:4] is field B.
REQ-004 The block SHALL have port Squash, input, 1 bit: branch taken; the instruction in IR3Out is discarded.
REQ-005 The block SHALL have port RFWrite, output, 1 bit: register-file write enable for the instruction in writeback; registered.
REQ-006 The block SHALL have port RegW, output, 2 bits: register-file write address; registered.
REQ-007 The block SHALL have port RegInSel, output, 2 bits: write-data select (0 = ALU result, 1 = MDR, 2 and 3 reserved and never driven); registered.
REQ-008 The block SHALL have port PCWrite, output, 1 bit: fetch/PC advance enable.
REQ-009 The block SHALL have port Halted, output, 1 bit: processor stopped.
REQ-010 The block SHALL have port RetiredCount, output, 16 bits: number of retired writing or non-writing instructions, excluding NOP and STOP.

Function
REQ-011 Opcode classes SHALL be:
- ASN = 0100, 0110, 1000
- SHIFT = [2:0] 011
- ORI = [2:0] 111
- LOAD = 0000
- STORE = 0010
- BPZ = 1101, BZ = 0101, BNZ = 1001
- NOP = 1010
- STOP = 0001
- any other opcode = NOP.
REQ-012 Each edge in state RUN SHALL latch a decode of IR3Out, treated as NOP when Squash = 1; the latched decode drives the writeback outputs for the following cycle (latency 1).
REQ-013 ASN and SHIFT SHALL give RFWrite = 1, RegW = IR[7:6], RegInSel = 0.
REQ-014 ORI SHALL give RFWrite = 1, RegW = 1, RegInSel = 0.
REQ-015 LOAD SHALL give RFWrite = 1, RegW = IR[7:6], RegInSel = 1.
REQ-016 STORE, branches, NOP and STOP SHALL give RFWrite = 0, RegW = 0, RegInSel = 0.
REQ-017 The FSM SHALL have states RUN, DRAIN and HALT.
REQ-018 In RUN, an unsquashed STOP in IR3Out SHALL move the FSM to DRAIN at the edge; Squash with STOP SHALL keep the FSM in RUN with the STOP discarded.
REQ-019 DRAIN SHALL last exactly one cycle and then go to HALT.
REQ-020 HALT SHALL hold until reset.
REQ-021 PCWrite SHALL be 1 only in RUN; Halted SHALL be 1 only in HALT; both are decoded from state.
REQ-022 In DRAIN and HALT, the block SHALL ignore IR3Out and Squash and SHALL force RFWrite = 0.
REQ-023 RetiredCount SHALL increment by 1 on each edge where a latched unsquashed non-NOP, non-STOP instruction leaves writeback, and SHALL saturate at 16'hFFFF.
REQ-024 RetiredCount SHALL NOT increment in DRAIN or HALT.

Reset
REQ-025 While reset = 0 at an edge, the block SHALL set state = RUN, RFWrite = 0, RegW = 0, RegInSel = 0 and RetiredCount = 0.
REQ-026 Reset SHALL make PCWrite = 1 and Halted = 0 from the cycle after that edge.
REQ-027 Reset asserted in any state, including mid-DRAIN, SHALL discard the pending writeback, with no partial write.

Structure
REQ-028 A shared package SHALL hold the opcode constants, the instruction-class enum (shared with the register-file controller) and the FSM state enum.
REQ-029 The opcode-to-class decode SHALL be a sub-module instr_decode, reused by the register-file controller.

Verification
REQ-030 The bench SHALL drive IR3Out = 8'b10_01_0100 -> next cycle RFWrite = 1, RegW = 2, RegInSel = 0, and RetiredCount 0 -> 1 one edge later.
REQ-031 The bench SHALL drive IR3Out = 8'b11_01_0000, then 8'b00101_111 -> LOAD cycle RFWrite = 1, RegW = 3, RegInSel = 1; ORI cycle RegW = 1, RegInSel = 0.
REQ-032 The bench SHALL drive STORE 8'b01_10_0010, then NOP 8'h0A, then BZ -> RFWrite = 0 each cycle, with count +1 for STORE, +0 for NOP, +1 for BZ.
REQ-033 The bench SHALL drive STOP 8'h01 at cycle n -> PCWrite = 0 from n+1, Halted = 1 from n+2, then an ADD applied afterwards gives RFWrite = 0 and count unchanged.
REQ-034 The bench SHALL drive Squash = 1 with ADD, and Squash = 1 with STOP -> RFWrite = 0 in both cases, FSM stays RUN, PCWrite stays 1.
REQ-035 The bench SHALL drive 65 540 consecutive ADDs, then reset = 0 for one edge -> RetiredCount holds 16'hFFFF, then reads 0 after reset.
